// File: rtl/mnist_pkg.sv
// mnist_pkg: shared sequencer state encodings and MNIST layer sizes
package mnist_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, WRITE, DONE} state_t;
  localparam int MNIST_INPUTS = 784;
  localparam int MNIST_NEURONS = 10;
endpackage

// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: memory address, MAC strobe and result handshake bundle
interface layer_sequencer_if #(
  parameter int IN_AW = 10,
  parameter int NEU_AW = 4
);
  logic [IN_AW-1:0] in_addr;
  logic [NEU_AW-1:0] neu_addr;
  logic [NEU_AW-1:0] out_addr;
  logic addr_valid;
  logic mac_clr;
  logic mac_en;
  logic mac_last;
  logic out_valid;
  logic out_ready;
  modport master (
    output in_addr, neu_addr, addr_valid, mac_clr, mac_en, mac_last, out_valid, out_addr,
    input out_ready
  );
  modport slave (
    input in_addr, neu_addr, addr_valid, mac_clr, mac_en, mac_last, out_valid, out_addr,
    output out_ready
  );
endinterface

// File: rtl/wrap_counter.sv
// wrap_counter: index counter with clear, increment and terminal-count flag
module wrap_counter #(
  parameter int WIDTH = 4,
  parameter int MAX = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);
  assign at_max = count == WIDTH'(MAX);
  // clear wins over increment; increment past MAX wraps to zero
  always_ff @(posedge clk)
    count <= (rst || clr) ? '0 : inc ? (at_max ? '0 : count + 1'b1) : count;
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: per-neuron address sweep, MAC strobes and result handoff for one FC layer
module layer_sequencer
  import mnist_pkg::*;
#(
  parameter int NUM_INPUTS = MNIST_INPUTS,
  parameter int NUM_NEURONS = MNIST_NEURONS,
  parameter int IN_AW = 10,
  parameter int NEU_AW = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  layer_sequencer_if.master bus
);
  state_t state, nxt;
  logic [IN_AW-1:0] in_idx;
  logic [NEU_AW-1:0] neu_idx;
  logic in_last, neu_last, av;
  logic [2:0] dcnt;
  assign av = state == FEED;
  wrap_counter #(.WIDTH(IN_AW), .MAX(NUM_INPUTS - 1)) u_in (
    .clk(clk), .rst(rst), .clr(state == CLEAR || abort), .inc(av && !in_last),
    .count(in_idx), .at_max(in_last)
  );
  wrap_counter #(.WIDTH(NEU_AW), .MAX(NUM_NEURONS - 1)) u_neu (
    .clk(clk), .rst(rst), .clr(state == IDLE),
    .inc(state == WRITE && bus.out_ready && !abort && !neu_last),
    .count(neu_idx), .at_max(neu_last)
  );
  // state register; drain counter runs only while in DRAIN
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : nxt;
    dcnt <= (rst || state != DRAIN) ? '0 : dcnt + 3'd1;
  end
  // next state; abort overrides every transition
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? CLEAR : IDLE;
      CLEAR:   nxt = FEED;
      FEED:    nxt = in_last ? (PIPE_LAT > 0 ? DRAIN : WRITE) : FEED;
      DRAIN:   nxt = dcnt == 3'(PIPE_LAT - 1) ? WRITE : DRAIN;
      WRITE:   nxt = bus.out_ready ? (neu_last ? DONE : CLEAR) : WRITE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  // state-decoded outputs; addresses read as zero outside their live cycles
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    bus.mac_clr = state == CLEAR;
    bus.addr_valid = av;
    bus.in_addr = av ? in_idx : '0;
    bus.neu_addr = av ? neu_idx : '0;
    bus.out_valid = state == WRITE;
    bus.out_addr = state == WRITE ? neu_idx : '0;
  end
  generate
    if (PIPE_LAT > 0) begin : g_pipe
      logic [PIPE_LAT-1:0] en_sr, last_sr;
      // align MAC strobes with operands arriving PIPE_LAT cycles after the address
      always_ff @(posedge clk) begin
        en_sr <= (rst || abort) ? '0 : PIPE_LAT'({en_sr, av});
        last_sr <= (rst || abort) ? '0 : PIPE_LAT'({last_sr, av && in_last});
      end
      assign bus.mac_en = en_sr[PIPE_LAT-1];
      assign bus.mac_last = last_sr[PIPE_LAT-1];
    end else begin : g_nopipe
      assign bus.mac_en = av;
      assign bus.mac_last = av && in_last;
    end
  endgenerate
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Controller for one fully-connected layer of the MNIST classifier.
- For each neuron in turn it:
  - clears the external MAC,
  - sweeps the input/weight memory addresses,
  - accounts for the memory/MAC pipeline latency,
  - hands the finished accumulator to the downstream stage (activation/argmax) over a valid/ready handshake.
- The block is control only: it generates addresses and strobes and never touches data.

Parameters:
- NUM_INPUTS, 784, inputs per neuron (>=1).
- NUM_NEURONS, 10, neurons in the layer (>=1).
- IN_AW, 10, input address width; 2^IN_AW >= NUM_INPUTS.
- NEU_AW, 4, neuron address width; 2^NEU_AW >= NUM_NEURONS.
- PIPE_LAT, 2, cycles from address issue to operand valid at the MAC (0..7).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a layer pass; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns the block to IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when all neurons have been written.
- in_addr  out  IN_AW  input/weight element index.
- neu_addr  out  NEU_AW  current neuron index (also the weight bank select).
- addr_valid  out  1  in_addr/neu_addr are a live read this cycle.
- mac_clr  out  1  clear the accumulator (one cycle per neuron).
- mac_en  out  1  accumulate operand this cycle (addr_valid delayed by PIPE_LAT).
- mac_last  out  1  coincides with mac_en for element NUM_INPUTS-1.
- out_valid  out  1  accumulator result is ready for neuron out_addr.
- out_addr  out  NEU_AW  neuron index of the result.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset:
  - state=IDLE; both indices=0; PIPE_LAT shift register cleared.
  - All outputs 0; addresses 0.
  - Reset mid-pass discards all progress; done is not pulsed.
- FSM states and transitions:
  - IDLE:
    - start=1 -> CLEAR with neu_idx=0.
    - start in any other state is ignored.
  - CLEAR:
    - mac_clr=1 for exactly one cycle; in_idx<=0 -> FEED.
  - FEED:
    - addr_valid=1, in_addr=in_idx, neu_addr=neu_idx; in_idx increments each cycle.
    - When in_idx==NUM_INPUTS-1 the state goes to DRAIN (PIPE_LAT>0) or WRITE (PIPE_LAT==0).
    - No wrap: in_idx never exceeds NUM_INPUTS-1.
  - DRAIN:
    - Lasts exactly PIPE_LAT cycles (drain counter), then -> WRITE.
    - addr_valid=0.
  - WRITE:
    - out_valid=1, out_addr=neu_idx.
    - Held stable until out_ready=1; may stall indefinitely.
    - On handshake: if neu_idx==NUM_NEURONS-1 -> DONE, else neu_idx++ and -> CLEAR.
  - DONE:
    - done=1 for one cycle -> IDLE.
    - start in this cycle is ignored.
- mac_en/mac_last pipeline:
  - Both are addr_valid and (addr_valid & in_idx==NUM_INPUTS-1) delayed through a PIPE_LAT-stage shift register.
  - Exactly NUM_INPUTS mac_en pulses per neuron.
  - The last mac_en occurs in the final DRAIN cycle, or in the final FEED cycle when PIPE_LAT=0.
  - out_valid rises the cycle after the last mac_en.
- Cycle count per neuron with out_ready tied high: 1 + NUM_INPUTS + PIPE_LAT + 1.
- Cycle count per layer: done occurs NUM_NEURONS*(NUM_INPUTS+PIPE_LAT+2)+1 cycles after the cycle in which start is sampled.
- abort:
  - From any non-IDLE state -> IDLE next cycle; outputs cleared and the shift register flushed; no done.
  - abort together with the out_ready handshake: abort wins, neu_idx does not advance, and downstream discards the pending result.
  - abort in IDLE has no effect.
  - abort together with start in IDLE: abort wins and the block stays IDLE.
- Edge cases:
  - NUM_INPUTS=1: FEED lasts one cycle.
  - NUM_NEURONS=1: WRITE goes straight to DONE.

Decomposition:
- Shared package mnist_pkg: state encodings (IDLE, CLEAR, FEED, DRAIN, WRITE, DONE) and layer-size constants (784, 10) for reuse by other layer instances.
- Sub-module wrap_counter (WIDTH, MAX parameters; ports clr, inc, count, at_max):
  - instantiated twice, once for in_idx and once for neu_idx;
  - the drain counter is a small local register.

Test Plan:
- NUM_INPUTS=4, NUM_NEURONS=3, PIPE_LAT=2, out_ready=1, start pulsed in cycle 0:
  - expected: CLEAR in cycle 1, in_addr 0..3 in cycles 2-5, mac_en cycles 4-7, mac_last cycle 7, out_valid cycle 8 (out_addr 0), 16 (1), 24 (2);
  - done pulses in cycle 25 only; busy is 1 in cycles 1-25.
- Same parameters, out_ready held 0 for 5 cycles in neuron 1's WRITE:
  - expected: out_valid/out_addr=1 held stable, no mac_clr; done delayed by exactly 5 cycles (cycle 30).
- PIPE_LAT=0, NUM_INPUTS=1, NUM_NEURONS=1:
  - expected: mac_en and mac_last coincide with addr_valid in cycle 2, out_valid in cycle 3, done in cycle 4.
- abort asserted in FEED with in_addr=2:
  - expected: IDLE next cycle, all outputs 0, no done;
  - a subsequent start restarts at neu_addr=0, in_addr=0 with exactly 4 mac_en per neuron.
- rst asserted in WRITE, and separately start pulsed while busy:
  - expected: reset forces IDLE with all outputs 0;
  - start while busy changes nothing (same cycle counts as the first scenario).
- Scenario 1 checker: count mac_clr pulses (=3) and mac_en pulses (=12); no mac_en is ever asserted in CLEAR or WRITE.
